// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile
//   Register file plus issue/writeback sequencer that feeds an external
//   32-bit combinational ALU. One instruction is accepted at a time via
//   instr_valid/instr_ready. It is sequenced IDLE -> EXEC -> WB -> IDLE,
//   which gives a throughput of one instruction every three cycles.
//   - IDLE: fetches the operands and registers alu_a/alu_b/alu_ctrl.
//   - EXEC: samples alu_result/alu_zero and writes back to the register
//     file. LOADI writes the immediate instead.
//   - WB:   holds the one-cycle wb_valid/illegal_op pulses.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid/instr_ready       instruction handshake (ready = IDLE)
//   instr_op/rd/rs1/rs2/imm       instruction fields
//   alu_a/alu_b/alu_ctrl          registered operands/opcode to the ALU
//   alu_result/alu_zero           ALU response
//   wb_valid/wb_rd/wb_data        retirement report (pulse + held values)
//   zero_flag                     zero of the last retired ALU op (held)
//   illegal_op                    one-cycle pulse for opcodes 1001..1111
//   dbg_addr/dbg_data             combinational debug read (R0 reads 0)
module alu_issue_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              illegal_op,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** REG_AW;
  localparam logic [3:0] OP_LOADI = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [NREGS];
  logic [3:0]          op_q;
  logic [REG_AW-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   rs1_val, rs2_val;

  // R0 is hardwired to zero on every read path.
  assign rs1_val  = (instr_rs1 == '0) ? '0 : rf_q[instr_rs1];
  assign rs2_val  = (instr_rs2 == '0) ? '0 : rf_q[instr_rs2];
  assign dbg_data = (dbg_addr  == '0) ? '0 : rf_q[dbg_addr];

  assign instr_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      zero_flag  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // Issue: latch the instruction and present the operands to the ALU.
        IDLE: begin
          if (instr_valid) begin
            op_q     <= instr_op;
            rd_q     <= instr_rd;
            imm_q    <= instr_imm;
            alu_a    <= rs1_val;
            alu_b    <= rs2_val;
            alu_ctrl <= instr_op;
          end
        end
        // Execute: the ALU output has been settling all cycle; retire here.
        EXEC: begin
          wb_rd <= rd_q;
          if (!op_q[3]) begin
            if (rd_q != '0) rf_q[rd_q] <= alu_result;
            wb_data   <= alu_result;
            zero_flag <= alu_zero;
            wb_valid  <= 1'b1;
          end else if (op_q == OP_LOADI) begin
            if (rd_q != '0) rf_q[rd_q] <= imm_q;
            wb_data  <= imm_q;
            wb_valid <= 1'b1;
          end else begin
            illegal_op <= 1'b1;
          end
        end
        // Writeback report: pulses last exactly this one cycle.
        WB: begin
          wb_valid   <= 1'b0;
          illegal_op <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_regfile.sv
module tb_alu_issue_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [3:0]  instr_rd, instr_rs1, instr_rs2;
  logic [31:0] instr_imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        zero_flag;
  logic        illegal_op;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_regfile #(.DATA_W(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .zero_flag(zero_flag), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in for the 32-bit combinational ALU.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b0011: alu_result = ~(alu_a | alu_b);
      4'b0100: alu_result = alu_a + alu_b;
      4'b0101: alu_result = alu_a - alu_b;
      4'b0110: alu_result = alu_a + 32'd1;
      4'b0111: alu_result = alu_a - 32'd1;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic        wbv;
    logic        ill;
    logic [31:0] data;
    logic        zf;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] rd,
                              input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic [31:0] imm, input logic wbv,
                              input logic ill, input logic [31:0] data,
                              input logic zf);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.wbv = wbv; v.ill = ill; v.data = data; v.zf = zf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge after WB.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".ready_idle"}, {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_op = v.op; instr_rd = v.rd; instr_rs1 = v.rs1;
    instr_rs2 = v.rs2; instr_imm = v.imm;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op = 4'hF; instr_rd = 4'hF; instr_rs1 = 4'hF; instr_rs2 = 4'hF;
    instr_imm = 32'hDEADBEEF;
    chk({tag, ".ready_exec"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, ".wbv_exec"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, v.op});
    @(negedge clk);
    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, v.wbv});
    chk({tag, ".illegal"}, {31'd0, illegal_op}, {31'd0, v.ill});
    chk({tag, ".wb_rd"}, {28'd0, wb_rd}, {28'd0, v.rd});
    chk({tag, ".wb_data"}, wb_data, v.data);
    chk({tag, ".zero_flag"}, {31'd0, zero_flag}, {31'd0, v.zf});
    chk({tag, ".ready_wb"}, {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk({tag, ".wbv_drop"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, ".ill_drop"}, {31'd0, illegal_op}, 32'd0);
  endtask

  task automatic dbg_chk(input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), dbg_data, exp);
  endtask

  initial begin
    logic [8:0] rdy_bits, wb_bits;
    //                op     rd    rs1   rs2   imm            wbv  ill  data           zf
    vecs[0]  = mk(4'h8, 4'd1, 4'd0, 4'd0, 32'hF0F0F0F0, 1, 0, 32'hF0F0F0F0, 0);
    vecs[1]  = mk(4'h8, 4'd2, 4'd0, 4'd0, 32'h0F0F0F0F, 1, 0, 32'h0F0F0F0F, 0);
    vecs[2]  = mk(4'h0, 4'd3, 4'd1, 4'd2, 32'h0,        1, 0, 32'h00000000, 1);
    vecs[3]  = mk(4'h1, 4'd4, 4'd1, 4'd2, 32'h0,        1, 0, 32'hFFFFFFFF, 0);
    vecs[4]  = mk(4'h8, 4'd5, 4'd0, 4'd0, 32'hA,        1, 0, 32'h0000000A, 0);
    vecs[5]  = mk(4'h8, 4'd6, 4'd0, 4'd0, 32'h5,        1, 0, 32'h00000005, 0);
    vecs[6]  = mk(4'h4, 4'd7, 4'd5, 4'd6, 32'h0,        1, 0, 32'h0000000F, 0);
    vecs[7]  = mk(4'h5, 4'd7, 4'd5, 4'd6, 32'h0,        1, 0, 32'h00000005, 0);
    vecs[8]  = mk(4'h6, 4'd10, 4'd5, 4'd6, 32'h0,       1, 0, 32'h0000000B, 0);
    vecs[9]  = mk(4'h7, 4'd11, 4'd5, 4'd6, 32'h0,       1, 0, 32'h00000009, 0);
    vecs[10] = mk(4'h8, 4'd1, 4'd0, 4'd0, 32'h1,        1, 0, 32'h00000001, 0);
    vecs[11] = mk(4'h5, 4'd8, 4'd1, 4'd1, 32'h0,        1, 0, 32'h00000000, 1);
    vecs[12] = mk(4'h8, 4'd9, 4'd0, 4'd0, 32'h0,        1, 0, 32'h00000000, 1);
    vecs[13] = mk(4'h4, 4'd0, 4'd1, 4'd1, 32'h0,        1, 0, 32'h00000002, 0);
    vecs[14] = mk(4'hB, 4'd2, 4'd1, 4'd1, 32'h12345678, 0, 1, 32'h00000002, 0);
    vecs[15] = mk(4'h8, 4'd12, 4'd0, 4'd0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 0);
    vecs[16] = mk(4'h6, 4'd13, 4'd12, 4'd0, 32'h0,      1, 0, 32'h00000000, 1);
    vecs[17] = mk(4'h2, 4'd14, 4'd1, 4'd2, 32'h0,       1, 0, 32'h0F0F0F0E, 0);
    vecs[18] = mk(4'h3, 4'd15, 4'd3, 4'd0, 32'h0,       1, 0, 32'hFFFFFFFF, 0);

    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0;
    instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    chk("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst.illegal", {31'd0, illegal_op}, 32'd0);
    chk("rst.zero_flag", {31'd0, zero_flag}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_rd", {28'd0, wb_rd}, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    chk("rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    dbg_chk(4'd5, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
      // DEC (vecs[9]) still forwards rf[rs2] on alu_b.
      if (i == 9) chk("dec.alu_b", alu_b, 32'h5);
    end

    dbg_chk(4'd0, 32'd0);
    dbg_chk(4'd2, 32'h0F0F0F0F);
    dbg_chk(4'd7, 32'h5);
    dbg_chk(4'd10, 32'hB);
    dbg_chk(4'd11, 32'h9);
    dbg_chk(4'd13, 32'h0);
    dbg_chk(4'd15, 32'hFFFFFFFF);
    dbg_chk(4'd1, 32'h1);
    @(negedge clk);

    // Reset in the middle of EXEC drops the instruction.
    instr_valid = 1'b1; instr_op = 4'h4; instr_rd = 4'd3;
    instr_rs1 = 4'd1; instr_rs2 = 4'd1; instr_imm = '0;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("mid.in_exec", {31'd0, instr_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.ready", {31'd0, instr_ready}, 32'd1);
    chk("mid.wb_valid", {31'd0, wb_valid}, 32'd0);
    dbg_chk(4'd3, 32'd0);
    dbg_chk(4'd1, 32'd0);
    @(negedge clk);
    chk("mid.wb_valid_later", {31'd0, wb_valid}, 32'd0);

    // Held instr_valid: accepted only every third cycle.
    instr_valid = 1'b1; instr_op = 4'h8; instr_rd = 4'd4;
    instr_rs1 = '0; instr_rs2 = '0; instr_imm = 32'h77;
    for (int i = 0; i < 9; i++) begin
      rdy_bits[i] = instr_ready;
      wb_bits[i]  = wb_valid;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("hold.ready_pattern", {23'd0, rdy_bits}, {23'd0, 9'b001001001});
    chk("hold.wb_pattern", {23'd0, wb_bits}, {23'd0, 9'b100100100});
    dbg_chk(4'd4, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
